// File: rtl/axis_rgb565_luma.sv
// Pairs RGB565 bytes from an AXI-Stream byte feed and emits one 8-bit luma byte per pixel.
// Two-register pipeline (packed pixel, then luma) with full valid/ready flow control and line statistics.
module axis_rgb565_luma #(
    parameter int WIDTH_P = 8,
    parameter int CNT_W_P = 12
) (
    input  logic               pclk_i,
    input  logic               rstn_i,
    input  logic [WIDTH_P-1:0] s_tdata_i,
    input  logic               s_tvalid_i,
    input  logic               s_tlast_i,
    output logic               s_tready_o,
    output logic [7:0]         m_tdata_o,
    output logic               m_tvalid_o,
    output logic               m_tlast_o,
    input  logic               m_tready_i,
    output logic [CNT_W_P-1:0] line_len_o,
    output logic               odd_line_o
);

    // BT.601-style weights on the bit-replicated 8-bit channels; the sum never exceeds 16 bits.
    function automatic logic [7:0] luma_f(input logic [15:0] pix);
        logic [4:0]  r5;
        logic [5:0]  g6;
        logic [4:0]  b5;
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [15:0] sum;
        r5  = pix[15:11];
        g6  = pix[10:5];
        b5  = pix[4:0];
        r8  = {r5, r5[4:2]};
        g8  = {g6, g6[5:4]};
        b8  = {b5, b5[4:2]};
        sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
        return sum[15:8];
    endfunction

    logic               phase_r;
    logic [WIDTH_P-1:0] hi_r;
    logic               p1_valid_r;
    logic [15:0]        p1_data_r;
    logic               p1_last_r;
    logic               m_tvalid_r;
    logic [7:0]         m_tdata_r;
    logic               m_tlast_r;
    logic [CNT_W_P-1:0] cnt_r;
    logic [CNT_W_P-1:0] line_len_r;
    logic               odd_line_r;

    logic               s_tready_s;
    logic               accept_s;
    logic               hi_acc_s;
    logic               lo_acc_s;
    logic               odd_acc_s;
    logic               p1_xfer_s;
    logic               out_hs_s;
    logic [CNT_W_P-1:0] cnt_inc_s;

    // Handshake strobes and the saturating count increment.
    always_comb begin
        s_tready_s = !p1_valid_r || !m_tvalid_r || m_tready_i;
        accept_s   = s_tvalid_i && s_tready_s;
        hi_acc_s   = accept_s && !phase_r && !s_tlast_i;
        lo_acc_s   = accept_s && phase_r;
        odd_acc_s  = accept_s && !phase_r && s_tlast_i;
        p1_xfer_s  = p1_valid_r && (!m_tvalid_r || m_tready_i);
        out_hs_s   = m_tvalid_r && m_tready_i;
        cnt_inc_s  = (cnt_r == {CNT_W_P{1'b1}}) ? cnt_r : cnt_r + {{(CNT_W_P-1){1'b0}}, 1'b1};
    end

    // Byte pairing; a tlast on a would-be hi byte drops it and flags an odd line.
    always_ff @(posedge pclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            phase_r    <= 1'b0;
            hi_r       <= {WIDTH_P{1'b0}};
            odd_line_r <= 1'b0;
        end else begin
            if (hi_acc_s) begin
                hi_r    <= s_tdata_i;
                phase_r <= 1'b1;
            end else if (lo_acc_s) begin
                phase_r <= 1'b0;
            end else begin
                phase_r <= phase_r;
            end
            odd_line_r <= odd_acc_s;
        end
    end

    // Stage 1 holds the packed pixel; it may load and drain on the same edge.
    always_ff @(posedge pclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            p1_valid_r <= 1'b0;
            p1_data_r  <= 16'd0;
            p1_last_r  <= 1'b0;
        end else begin
            if (lo_acc_s) begin
                p1_valid_r <= 1'b1;
                p1_data_r  <= {hi_r, s_tdata_i};
                p1_last_r  <= s_tlast_i;
            end else if (p1_xfer_s) begin
                p1_valid_r <= 1'b0;
            end else begin
                p1_valid_r <= p1_valid_r;
            end
        end
    end

    // Stage 2 is the output register; data and last hold while stalled.
    always_ff @(posedge pclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= 8'd0;
            m_tlast_r  <= 1'b0;
        end else begin
            if (p1_xfer_s) begin
                m_tvalid_r <= 1'b1;
                m_tdata_r  <= luma_f(p1_data_r);
                m_tlast_r  <= p1_last_r;
            end else if (m_tready_i) begin
                m_tvalid_r <= 1'b0;
            end else begin
                m_tvalid_r <= m_tvalid_r;
            end
        end
    end

    // Per-line pixel count, latched into line_len on the last handshake of a line.
    always_ff @(posedge pclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_r      <= {CNT_W_P{1'b0}};
            line_len_r <= {CNT_W_P{1'b0}};
        end else begin
            if (out_hs_s && m_tlast_r) begin
                line_len_r <= cnt_inc_s;
                cnt_r      <= {CNT_W_P{1'b0}};
            end else if (out_hs_s) begin
                cnt_r <= cnt_inc_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign s_tready_o = s_tready_s;
    assign m_tdata_o  = m_tdata_r;
    assign m_tvalid_o = m_tvalid_r;
    assign m_tlast_o  = m_tlast_r;
    assign line_len_o = line_len_r;
    assign odd_line_o = odd_line_r;

endmodule

// File: tb/tb_axis_rgb565_luma.sv
// Self-checking bench for axis_rgb565_luma: directed scenarios plus randomized streams
// checked against a byte-level reference model; a second instance uses a 4-bit line counter.
module tb_axis_rgb565_luma;

    logic        clk;
    logic        rstn;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        m_tready;
    logic        s_tready,  s_tready4;
    logic [7:0]  m_tdata,   m_tdata4;
    logic        m_tvalid,  m_tvalid4;
    logic        m_tlast,   m_tlast4;
    logic [11:0] line_len;
    logic [3:0]  line_len4;
    logic        odd_line,  odd_line4;

    int errors = 0;
    int checks = 0;

    axis_rgb565_luma u_dut (
        .pclk_i(clk), .rstn_i(rstn), .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid),
        .s_tlast_i(s_tlast), .s_tready_o(s_tready), .m_tdata_o(m_tdata),
        .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tready_i(m_tready),
        .line_len_o(line_len), .odd_line_o(odd_line)
    );

    axis_rgb565_luma #(.WIDTH_P(8), .CNT_W_P(4)) u_dut4 (
        .pclk_i(clk), .rstn_i(rstn), .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid),
        .s_tlast_i(s_tlast), .s_tready_o(s_tready4), .m_tdata_o(m_tdata4),
        .m_tvalid_o(m_tvalid4), .m_tlast_o(m_tlast4), .m_tready_i(m_tready),
        .line_len_o(line_len4), .odd_line_o(odd_line4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus bytes, model expectations, observations
    logic [7:0] in_b[$];
    bit         in_l[$];
    int         exp_d[$];
    bit         exp_last[$];
    int         exp_len12[$];
    int         exp_len4[$];
    int         exp_odd;
    int         obs_d[$];
    bit         obs_last[$];
    int         obs_len12[$];
    int         obs_len4[$];
    int         obs_odd;
    int         stab_err;
    int         rdy_err;
    int         stall_seen;
    bit         timed_out;

    function automatic int ref_luma(input int pix);
        int r5, g6, b5, r8, g8, b8;
        r5 = (pix / 2048) % 32;
        g6 = (pix / 32) % 64;
        b5 = pix % 32;
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    task automatic clear_stim();
        in_b.delete(); in_l.delete();
    endtask

    task automatic add_byte(input logic [7:0] b, input bit l);
        in_b.push_back(b); in_l.push_back(l);
    endtask

    task automatic add_pixel(input logic [15:0] p, input bit l);
        add_byte(p[15:8], 1'b0);
        add_byte(p[7:0], l);
    endtask

    // Reference: pair bytes in order, drop a tlast byte that arrives as a hi byte.
    task automatic build_model();
        bit have_hi;
        int hi, cnt;
        exp_d.delete(); exp_last.delete(); exp_len12.delete(); exp_len4.delete();
        exp_odd = 0; have_hi = 0; hi = 0; cnt = 0;
        for (int i = 0; i < in_b.size(); i++) begin
            if (!have_hi) begin
                if (in_l[i]) exp_odd++;
                else begin hi = in_b[i]; have_hi = 1; end
            end else begin
                exp_d.push_back(ref_luma(hi * 256 + in_b[i]));
                exp_last.push_back(in_l[i]);
                cnt++;
                have_hi = 0;
                if (in_l[i]) begin
                    exp_len12.push_back(cnt > 4095 ? 4095 : cnt);
                    exp_len4.push_back(cnt > 15 ? 15 : cnt);
                    cnt = 0;
                end
            end
        end
    endtask

    // Streams in_b/in_l with random valid/ready gaps and records what the DUT emits.
    task automatic run_bytes(input int ready_pct, input int valid_pct);
        int  idx, cyc, tail;
        bit  pend_len, prev_stall;
        logic [7:0] prev_d;
        logic prev_l;
        obs_d.delete(); obs_last.delete(); obs_len12.delete(); obs_len4.delete();
        obs_odd = 0; stab_err = 0; rdy_err = 0; stall_seen = 0;
        idx = 0; tail = 0; pend_len = 0; prev_stall = 0; prev_d = 8'd0; prev_l = 1'b0;
        for (cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (pend_len) begin
                obs_len12.push_back(int'(line_len));
                obs_len4.push_back(int'(line_len4));
                pend_len = 0;
            end
            if (odd_line) obs_odd++;
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l))
                stab_err++;
            s_tvalid = (idx < in_b.size()) && ($urandom_range(99, 0) < valid_pct);
            s_tdata  = (idx < in_b.size()) ? in_b[idx] : 8'h00;
            s_tlast  = (idx < in_b.size()) ? in_l[idx] : 1'b0;
            m_tready = ($urandom_range(99, 0) < ready_pct);
            #1;
            if (m_tready && !s_tready) rdy_err++;
            if (!s_tready) stall_seen++;
            if (s_tvalid && s_tready) idx++;
            if (m_tvalid && m_tready) begin
                obs_d.push_back(int'(m_tdata));
                obs_last.push_back(m_tlast);
                if (m_tlast) pend_len = 1;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
            if (idx == in_b.size() && obs_d.size() >= exp_d.size()) tail++;
            if (tail > 3) break;
        end
        timed_out = (idx != in_b.size()) || (obs_d.size() < exp_d.size());
    endtask

    task automatic test_reset();
        rstn = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_out: valid=%b data=%h last=%b, want 0/00/0", m_tvalid, m_tdata, m_tlast);
        end
        checks++;
        if (line_len !== 12'd0 || odd_line !== 1'b0 || s_tready !== 1'b1) begin
            errors++; $display("FAIL reset_misc: len=%0d odd=%b rdy=%b, want 0/0/1", line_len, odd_line, s_tready);
        end
    endtask

    task automatic test_colour_primaries();
        int want[4] = '{76, 149, 28, 255};
        clear_stim();
        add_pixel(16'hF800, 1'b0); add_pixel(16'h07E0, 1'b0);
        add_pixel(16'h001F, 1'b0); add_pixel(16'hFFFF, 1'b1);
        build_model();
        run_bytes(100, 100);
        checks++;
        if (timed_out || obs_d.size() != 4) begin
            errors++; $display("FAIL colour_count: got %0d pixels, want 4", obs_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_d[i] !== want[i] || obs_last[i] !== (i == 3)) begin
                    errors++; $display("FAIL colour_px%0d: got %0d last=%b, want %0d last=%b", i, obs_d[i], obs_last[i], want[i], (i == 3));
                end
            end
        end
        checks++;
        if (obs_len12.size() != 1 || obs_len12[0] !== 4) begin
            errors++; $display("FAIL colour_len: got %0d entries first=%0d, want one of 4", obs_len12.size(), (obs_len12.size() > 0) ? obs_len12[0] : -1);
        end
    endtask

    // Lo accepted at edge N+1: edge N+2 still samples valid=0, edge N+3 samples valid=1.
    task automatic test_latency();
        @(negedge clk);
        s_tvalid = 1'b1; s_tdata = 8'h00; s_tlast = 1'b0; m_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_tlast = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++; $display("FAIL latency_early: valid=%b before edge N+2, want 0", m_tvalid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'h00 || m_tlast !== 1'b1) begin
            errors++; $display("FAIL latency_out: valid=%b data=%h last=%b at edge N+3, want 1/00/1", m_tvalid, m_tdata, m_tlast);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b0 || line_len !== 12'd1) begin
            errors++; $display("FAIL latency_after: valid=%b len=%0d, want 0/1", m_tvalid, line_len);
        end
    endtask

    task automatic test_odd_line();
        clear_stim();
        add_byte(8'hF8, 1'b0); add_byte(8'h00, 1'b0); add_byte(8'hAA, 1'b1);
        add_byte(8'h07, 1'b0); add_byte(8'hE0, 1'b1);
        build_model();
        run_bytes(100, 100);
        checks++;
        if (timed_out || obs_d.size() != 2) begin
            errors++; $display("FAIL odd_count: got %0d pixels, want 2", obs_d.size());
        end else begin
            checks++;
            if (obs_d[0] !== 76 || obs_last[0] !== 1'b0) begin
                errors++; $display("FAIL odd_px0: got %0d last=%b, want 76 last=0", obs_d[0], obs_last[0]);
            end
            checks++;
            if (obs_d[1] !== 149 || obs_last[1] !== 1'b1) begin
                errors++; $display("FAIL odd_px1: got %0d last=%b, want 149 last=1", obs_d[1], obs_last[1]);
            end
        end
        checks++;
        if (obs_odd !== 1) begin
            errors++; $display("FAIL odd_pulse: got %0d pulse cycles, want 1", obs_odd);
        end
        checks++;
        if (obs_len12.size() != 1 || obs_len12[0] !== 2) begin
            errors++; $display("FAIL odd_len: got %0d entries first=%0d, want one of 2", obs_len12.size(), (obs_len12.size() > 0) ? obs_len12[0] : -1);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        m_tready = 1'b0; s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 8'hF8;
        @(posedge clk); @(negedge clk); s_tdata = 8'h00;
        @(posedge clk); @(negedge clk); s_tdata = 8'h07;
        @(posedge clk); @(negedge clk); s_tvalid = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b1 || line_len === 12'd0) begin
            errors++; $display("FAIL arst_setup: valid=%b len=%0d, want 1 and nonzero", m_tvalid, line_len);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0 || line_len !== 12'd0 || odd_line !== 1'b0) begin
            errors++; $display("FAIL arst_clear: valid=%b data=%h last=%b len=%0d odd=%b, want all 0", m_tvalid, m_tdata, m_tlast, line_len, odd_line);
        end
        @(negedge clk);
        rstn = 1'b1;
        clear_stim();
        add_pixel(16'h07E0, 1'b1);
        build_model();
        run_bytes(100, 100);
        checks++;
        if (timed_out || obs_d.size() != 1 || obs_d[0] !== 149 || obs_last[0] !== 1'b1) begin
            errors++; $display("FAIL arst_after: got %0d pixels first=%0d, want one pixel 149", obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] base;
        base = 16'($urandom);
        clear_stim();
        for (int i = 0; i < 64; i++) add_pixel(base + 16'(i), (i == 63));
        build_model();
        run_bytes(50, 100);
        checks++;
        if (timed_out || obs_d.size() != exp_d.size()) begin
            errors++; $display("FAIL bp_count: got %0d pixels, want %0d", obs_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                checks++;
                if (obs_d[i] !== exp_d[i] || obs_last[i] !== exp_last[i]) begin
                    errors++; $display("FAIL bp_px%0d: got %0d last=%b, want %0d last=%b", i, obs_d[i], obs_last[i], exp_d[i], exp_last[i]);
                end
            end
        end
        checks++;
        if (stab_err !== 0 || rdy_err !== 0) begin
            errors++; $display("FAIL bp_stable: stall changes=%0d ready drops with m_tready=1: %0d, want 0/0", stab_err, rdy_err);
        end
        checks++;
        if (stall_seen == 0) begin
            errors++; $display("FAIL bp_full: s_tready low for %0d cycles, want at least 1", stall_seen);
        end
        checks++;
        if (obs_len12.size() != 1 || obs_len12[0] !== 64 || obs_len4.size() != 1 || obs_len4[0] !== 15) begin
            errors++; $display("FAIL bp_len: got %0d/%0d, want 64/15", (obs_len12.size() > 0) ? obs_len12[0] : -1, (obs_len4.size() > 0) ? obs_len4[0] : -1);
        end
    endtask

    task automatic test_saturation();
        clear_stim();
        for (int i = 0; i < 20; i++) add_pixel(16'($urandom), (i == 19));
        build_model();
        run_bytes(100, 100);
        checks++;
        if (timed_out || obs_d.size() != 20) begin
            errors++; $display("FAIL sat_count: got %0d pixels, want 20", obs_d.size());
        end
        checks++;
        if (obs_len4.size() != 1 || obs_len4[0] !== 15 || obs_len12.size() != 1 || obs_len12[0] !== 20) begin
            errors++; $display("FAIL sat_len: got %0d/%0d, want 15/20", (obs_len4.size() > 0) ? obs_len4[0] : -1, (obs_len12.size() > 0) ? obs_len12[0] : -1);
        end
    endtask

    task automatic test_random_lines();
        int nbytes;
        clear_stim();
        for (int ln = 0; ln < 6; ln++) begin
            nbytes = $urandom_range(13, 1);
            for (int j = 0; j < nbytes; j++) add_byte(8'($urandom), (j == nbytes - 1));
        end
        build_model();
        run_bytes(70, 80);
        checks++;
        if (timed_out || obs_d.size() != exp_d.size()) begin
            errors++; $display("FAIL rnd_count: got %0d pixels, want %0d", obs_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                checks++;
                if (obs_d[i] !== exp_d[i] || obs_last[i] !== exp_last[i]) begin
                    errors++; $display("FAIL rnd_px%0d: got %0d last=%b, want %0d last=%b", i, obs_d[i], obs_last[i], exp_d[i], exp_last[i]);
                end
            end
        end
        checks++;
        if (obs_odd !== exp_odd || obs_len12.size() != exp_len12.size()) begin
            errors++; $display("FAIL rnd_lines: odd=%0d lens=%0d, want odd=%0d lens=%0d", obs_odd, obs_len12.size(), exp_odd, exp_len12.size());
        end else begin
            for (int i = 0; i < exp_len12.size(); i++) begin
                checks++;
                if (obs_len12[i] !== exp_len12[i] || obs_len4[i] !== exp_len4[i]) begin
                    errors++; $display("FAIL rnd_len%0d: got %0d/%0d, want %0d/%0d", i, obs_len12[i], obs_len4[i], exp_len12[i], exp_len4[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_colour_primaries();
        test_latency();
        test_odd_line();
        test_async_reset();
        test_backpressure();
        test_saturation();
        test_random_lines();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
